// File: rtl/ysyx_24110006_mem_arbiter_if.sv
// Signal bundle between the IFU/LSU masters, the memory arbiter and the memory slave.
// No logic inside; all timing is set by the arbiter that drives the o_* members.
// Backpressure is carried by i_mem_ready (request accept) and i_mem_rvalid (response).
// Ports: modport master = arbiter view (drives grants, responses, memory request);
//        modport slave  = environment view (IFU/LSU masters and the memory slave).
interface ysyx_24110006_mem_arbiter_if;
  // IFU side
  logic        i_ifu_req;
  logic [31:0] i_ifu_addr;
  logic        o_ifu_gnt;
  logic        o_ifu_rvalid;
  logic [31:0] o_ifu_rdata;
  logic        o_ifu_err;
  // LSU side
  logic        i_lsu_req;
  logic        i_lsu_wen;
  logic [31:0] i_lsu_addr;
  logic [31:0] i_lsu_wdata;
  logic [3:0]  i_lsu_wmask;
  logic [2:0]  i_lsu_size;
  logic        o_lsu_gnt;
  logic        o_lsu_rvalid;
  logic [31:0] o_lsu_rdata;
  logic        o_lsu_err;
  // Memory side
  logic        o_mem_valid;
  logic        o_mem_wen;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_wmask;
  logic [2:0]  o_mem_size;
  logic        i_mem_ready;
  logic        i_mem_rvalid;
  logic [31:0] i_mem_rdata;
  logic        i_mem_err;
  // Status
  logic        o_busy;
  logic        o_owner;

  modport master (
    input  i_ifu_req, i_ifu_addr,
    output o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    input  i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask, i_lsu_size,
    output o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    output o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask, o_mem_size,
    input  i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err,
    output o_busy, o_owner
  );

  modport slave (
    output i_ifu_req, i_ifu_addr,
    input  o_ifu_gnt, o_ifu_rvalid, o_ifu_rdata, o_ifu_err,
    output i_lsu_req, i_lsu_wen, i_lsu_addr, i_lsu_wdata, i_lsu_wmask, i_lsu_size,
    input  o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata, o_lsu_err,
    input  o_mem_valid, o_mem_wen, o_mem_addr, o_mem_wdata, o_mem_wmask, o_mem_size,
    output i_mem_ready, i_mem_rvalid, i_mem_rdata, i_mem_err,
    input  o_busy, o_owner
  );
endinterface

// File: rtl/ysyx_24110006_mem_arbiter.sv
// Two-master (IFU/LSU) memory arbiter, one outstanding transaction, round-robin on ties.
// Latency: req -> gnt/o_mem_valid +1 cycle; mem rvalid -> master rvalid +1 cycle (min 3 total).
// Backpressure: o_mem_valid held until i_mem_ready; requests outside IDLE are ignored, not queued.
// Ports: i_clock, i_reset (async, active-high), bus (ysyx_24110006_mem_arbiter_if.master).
module ysyx_24110006_mem_arbiter #(
  parameter int TIMEOUT = 255  // RESP cycles before a forced error response; 0 disables
) (
  input logic                         i_clock,
  input logic                         i_reset,
  ysyx_24110006_mem_arbiter_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic        wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wmask;
    logic [2:0]  size;
  } mem_req_t;

  localparam logic [15:0] TIMEOUT_CNT = 16'(TIMEOUT);

  state_t      state, state_nxt;
  logic        owner;       // 0 = IFU, 1 = LSU; doubles as last owner for round-robin
  mem_req_t    payload;
  logic [15:0] resp_cnt;

  logic        ifu_gnt_q, lsu_gnt_q;
  logic        ifu_rvalid_q, lsu_rvalid_q;
  logic        ifu_err_q, lsu_err_q;
  logic [31:0] ifu_rdata_q, lsu_rdata_q;

  logic        any_req, pick_lsu, accept;
  logic        timed_out, resp_done, resp_err;
  logic [31:0] resp_rdata;

  // Arbitration and response qualification.
  always_comb begin
    any_req   = bus.i_ifu_req | bus.i_lsu_req;
    // On a tie, the master that did not own the previous transaction wins.
    pick_lsu  = bus.i_lsu_req & (~bus.i_ifu_req | ~owner);
    accept    = (state == IDLE) & any_req;
    // A real response in the same cycle as the timeout takes priority.
    timed_out = (state == RESP) & ~bus.i_mem_rvalid & (TIMEOUT_CNT != 16'd0)
              & (resp_cnt == TIMEOUT_CNT);
    resp_done = ((state == RESP) & bus.i_mem_rvalid) | timed_out;
    resp_rdata = timed_out ? 32'd0 : bus.i_mem_rdata;
    resp_err   = timed_out ? 1'b1 : bus.i_mem_err;
  end

  // State register.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = REQ;
      REQ:     if (bus.i_mem_ready) state_nxt = RESP;
      RESP:    if (resp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs: memory strobe and busy decode from state, everything else is registered.
  always_comb begin
    bus.o_mem_valid  = (state == REQ);
    bus.o_busy       = (state != IDLE);
    bus.o_owner      = owner;
    bus.o_mem_wen    = payload.wen;
    bus.o_mem_addr   = payload.addr;
    bus.o_mem_wdata  = payload.wdata;
    bus.o_mem_wmask  = payload.wmask;
    bus.o_mem_size   = payload.size;
    bus.o_ifu_gnt    = ifu_gnt_q;
    bus.o_ifu_rvalid = ifu_rvalid_q;
    bus.o_ifu_rdata  = ifu_rdata_q;
    bus.o_ifu_err    = ifu_err_q;
    bus.o_lsu_gnt    = lsu_gnt_q;
    bus.o_lsu_rvalid = lsu_rvalid_q;
    bus.o_lsu_rdata  = lsu_rdata_q;
    bus.o_lsu_err    = lsu_err_q;
  end

  // Owner, payload latch, timeout counter and one-cycle grant/response pulses.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      owner        <= 1'b0;
      payload      <= '0;
      resp_cnt     <= 16'd0;
      ifu_gnt_q    <= 1'b0;
      lsu_gnt_q    <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
      ifu_rdata_q  <= 32'd0;
      lsu_rdata_q  <= 32'd0;
    end else begin
      // Pulses default low; rdata/err are zero whenever rvalid is.
      ifu_gnt_q    <= 1'b0;
      lsu_gnt_q    <= 1'b0;
      ifu_rvalid_q <= 1'b0;
      lsu_rvalid_q <= 1'b0;
      ifu_err_q    <= 1'b0;
      lsu_err_q    <= 1'b0;
      ifu_rdata_q  <= 32'd0;
      lsu_rdata_q  <= 32'd0;

      if (accept) begin
        owner     <= pick_lsu;
        ifu_gnt_q <= ~pick_lsu;
        lsu_gnt_q <= pick_lsu;
        if (pick_lsu) begin
          payload <= '{wen:   bus.i_lsu_wen,
                       addr:  bus.i_lsu_addr,
                       wdata: bus.i_lsu_wdata,
                       wmask: bus.i_lsu_wmask,
                       size:  bus.i_lsu_size};
        end else begin
          // Fetches are always aligned word reads.
          payload <= '{wen:   1'b0,
                       addr:  bus.i_ifu_addr,
                       wdata: 32'd0,
                       wmask: 4'd0,
                       size:  3'b010};
        end
      end

      if ((state == REQ) && bus.i_mem_ready) begin
        resp_cnt <= 16'd0;
      end else if ((state == RESP) && !resp_done) begin
        resp_cnt <= resp_cnt + 16'd1;
      end

      if (resp_done) begin
        ifu_rvalid_q <= ~owner;
        lsu_rvalid_q <= owner;
        ifu_rdata_q  <= owner ? 32'd0 : resp_rdata;
        lsu_rdata_q  <= owner ? resp_rdata : 32'd0;
        ifu_err_q    <= ~owner & resp_err;
        lsu_err_q    <= owner & resp_err;
      end
    end
  end

endmodule

// File: tb/tb_ysyx_24110006_mem_arbiter.sv
// Self-checking bench for the IFU/LSU memory arbiter: directed cases plus randomized transactions.
// Expected behaviour comes from a per-transaction timeline (grant, REQ hold, RESP wait, pulse).
// Ports: none; instantiates the arbiter interface and drives it from the environment side.
module tb_ysyx_24110006_mem_arbiter;

  localparam int TO = 4;

  logic i_clock = 1'b0;
  logic i_reset = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;
  logic last_owner;  // reference model: owner of the previous transaction

  ysyx_24110006_mem_arbiter_if b ();

  ysyx_24110006_mem_arbiter #(.TIMEOUT(TO)) dut (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .bus     (b.master)
  );

  always #5 i_clock = ~i_clock;

  task automatic tick();
    @(posedge i_clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_busy"},       32'(b.o_busy), 32'd0);
    chk({tag, "_owner"},      32'(b.o_owner), 32'd0);
    chk({tag, "_mem_valid"},  32'(b.o_mem_valid), 32'd0);
    chk({tag, "_mem_wen"},    32'(b.o_mem_wen), 32'd0);
    chk({tag, "_mem_addr"},   b.o_mem_addr, 32'd0);
    chk({tag, "_mem_wdata"},  b.o_mem_wdata, 32'd0);
    chk({tag, "_mem_wmask"},  32'(b.o_mem_wmask), 32'd0);
    chk({tag, "_mem_size"},   32'(b.o_mem_size), 32'd0);
    chk({tag, "_ifu_gnt"},    32'(b.o_ifu_gnt), 32'd0);
    chk({tag, "_lsu_gnt"},    32'(b.o_lsu_gnt), 32'd0);
    chk({tag, "_ifu_rvalid"}, 32'(b.o_ifu_rvalid), 32'd0);
    chk({tag, "_ifu_rdata"},  b.o_ifu_rdata, 32'd0);
    chk({tag, "_ifu_err"},    32'(b.o_ifu_err), 32'd0);
    chk({tag, "_lsu_rvalid"}, 32'(b.o_lsu_rvalid), 32'd0);
    chk({tag, "_lsu_rdata"},  b.o_lsu_rdata, 32'd0);
    chk({tag, "_lsu_err"},    32'(b.o_lsu_err), 32'd0);
  endtask

  task automatic chk_rsp(input string tag, input logic iv, input logic lv,
                         input logic [31:0] d, input logic e);
    chk({tag, "_ifu_rvalid"}, 32'(b.o_ifu_rvalid), 32'(iv));
    chk({tag, "_ifu_rdata"},  b.o_ifu_rdata, iv ? d : 32'd0);
    chk({tag, "_ifu_err"},    32'(b.o_ifu_err), 32'(iv & e));
    chk({tag, "_lsu_rvalid"}, 32'(b.o_lsu_rvalid), 32'(lv));
    chk({tag, "_lsu_rdata"},  b.o_lsu_rdata, lv ? d : 32'd0);
    chk({tag, "_lsu_err"},    32'(b.o_lsu_err), 32'(lv & e));
  endtask

  task automatic randomize_masters();
    b.i_ifu_req   = 1'($urandom_range(0, 1));
    b.i_lsu_req   = 1'($urandom_range(0, 1));
    b.i_ifu_addr  = $urandom;
    b.i_lsu_wen   = 1'($urandom_range(0, 1));
    b.i_lsu_addr  = $urandom;
    b.i_lsu_wdata = $urandom;
    b.i_lsu_wmask = 4'($urandom_range(0, 15));
    b.i_lsu_size  = 3'($urandom_range(0, 7));
  endtask

  // One transaction starting in the current (IDLE) cycle. d_r: cycles of ready low in REQ;
  // d_v: RESP cycles before the slave answers (beyond TO means the slave never answers).
  // Returns in the cycle the master response pulses, with both requests dropped.
  task automatic run_txn(input string tag, input logic ireq, input logic lreq,
                         input logic [31:0] iaddr, input logic lwen, input logic [31:0] laddr,
                         input logic [31:0] lwdata, input logic [3:0] lwmask,
                         input logic [2:0] lsize, input int d_r, input int d_v,
                         input logic [31:0] rdata, input logic rerr);
    logic        own;
    logic        ewen;
    logic [31:0] eaddr, ewdata, e_rdata;
    logic [3:0]  emask;
    logic [2:0]  esize;
    logic        e_err;
    int          j_end;

    own = (ireq && lreq) ? ~last_owner : lreq;
    if (own) begin
      ewen = lwen; eaddr = laddr; ewdata = lwdata; emask = lwmask; esize = lsize;
    end else begin
      ewen = 1'b0; eaddr = iaddr; ewdata = 32'd0; emask = 4'd0; esize = 3'b010;
    end
    if (d_v <= TO) begin
      j_end = d_v; e_rdata = rdata; e_err = rerr;
    end else begin
      j_end = TO; e_rdata = 32'd0; e_err = 1'b1;
    end

    // IDLE cycle carrying the request; stray slave activity must be ignored.
    b.i_ifu_req = ireq; b.i_ifu_addr = iaddr;
    b.i_lsu_req = lreq; b.i_lsu_wen = lwen; b.i_lsu_addr = laddr;
    b.i_lsu_wdata = lwdata; b.i_lsu_wmask = lwmask; b.i_lsu_size = lsize;
    b.i_mem_ready  = 1'($urandom_range(0, 1));
    b.i_mem_rvalid = 1'($urandom_range(0, 1));
    b.i_mem_rdata  = $urandom;
    b.i_mem_err    = 1'($urandom_range(0, 1));
    chk({tag, "_c0_busy"},      32'(b.o_busy), 32'd0);
    chk({tag, "_c0_mem_valid"}, 32'(b.o_mem_valid), 32'd0);
    chk({tag, "_c0_gnt"},       32'({b.o_ifu_gnt, b.o_lsu_gnt}), 32'd0);
    tick();

    // REQ: payload held stable while masters wiggle their inputs.
    for (int k = 0; k <= d_r; k++) begin
      randomize_masters();
      b.i_mem_ready  = (k == d_r);
      b.i_mem_rvalid = 1'($urandom_range(0, 1));
      b.i_mem_rdata  = $urandom;
      chk({tag, "_req_ifu_gnt"}, 32'(b.o_ifu_gnt), 32'(k == 0 && !own));
      chk({tag, "_req_lsu_gnt"}, 32'(b.o_lsu_gnt), 32'(k == 0 && own));
      chk({tag, "_req_valid"},   32'(b.o_mem_valid), 32'd1);
      chk({tag, "_req_busy"},    32'(b.o_busy), 32'd1);
      chk({tag, "_req_owner"},   32'(b.o_owner), 32'(own));
      chk({tag, "_req_wen"},     32'(b.o_mem_wen), 32'(ewen));
      chk({tag, "_req_addr"},    b.o_mem_addr, eaddr);
      chk({tag, "_req_wdata"},   b.o_mem_wdata, ewdata);
      chk({tag, "_req_wmask"},   32'(b.o_mem_wmask), 32'(emask));
      chk({tag, "_req_size"},    32'(b.o_mem_size), 32'(esize));
      chk_rsp({tag, "_req"}, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end

    // RESP: wait for the slave or the timeout.
    for (int j = 0; j <= j_end; j++) begin
      randomize_masters();
      b.i_mem_ready  = 1'($urandom_range(0, 1));
      b.i_mem_rvalid = (j == d_v);
      b.i_mem_rdata  = (j == d_v) ? rdata : $urandom;
      b.i_mem_err    = (j == d_v) ? rerr : 1'($urandom_range(0, 1));
      chk({tag, "_resp_valid"}, 32'(b.o_mem_valid), 32'd0);
      chk({tag, "_resp_busy"},  32'(b.o_busy), 32'd1);
      chk({tag, "_resp_gnt"},   32'({b.o_ifu_gnt, b.o_lsu_gnt}), 32'd0);
      chk_rsp({tag, "_resp"}, 1'b0, 1'b0, 32'd0, 1'b0);
      tick();
    end

    // Response pulse cycle (IDLE again).
    b.i_ifu_req = 1'b0; b.i_lsu_req = 1'b0;
    b.i_mem_rvalid = 1'b0; b.i_mem_ready = 1'b0;
    chk_rsp({tag, "_done"}, ~own, own, e_rdata, e_err);
    chk({tag, "_done_busy"},  32'(b.o_busy), 32'd0);
    chk({tag, "_done_valid"}, 32'(b.o_mem_valid), 32'd0);
    chk({tag, "_done_owner"}, 32'(b.o_owner), 32'(own));
    last_owner = own;
  endtask

  initial begin
    b.i_ifu_req = 1'b0; b.i_ifu_addr = 32'd0;
    b.i_lsu_req = 1'b0; b.i_lsu_wen = 1'b0; b.i_lsu_addr = 32'd0;
    b.i_lsu_wdata = 32'd0; b.i_lsu_wmask = 4'd0; b.i_lsu_size = 3'd0;
    b.i_mem_ready = 1'b0; b.i_mem_rvalid = 1'b0; b.i_mem_rdata = 32'd0; b.i_mem_err = 1'b0;
    i_reset = 1'b1;
    repeat (2) tick();
    chk_all_zero("reset");
    i_reset = 1'b0;
    last_owner = 1'b0;

    // Tie from reset: LSU first, then alternation while both keep asking.
    run_txn("tie0", 1, 1, 32'h8000_0010, 0, 32'h8000_0400, 32'd0, 4'd0, 3'b010, 0, 0, 32'h1111_1111, 0);
    run_txn("tie1", 1, 1, 32'h8000_0014, 0, 32'h8000_0404, 32'd0, 4'd0, 3'b010, 0, 0, 32'h2222_2222, 0);
    run_txn("tie2", 1, 1, 32'h8000_0018, 1, 32'h8000_0408, 32'h5, 4'hF, 3'b010, 0, 1, 32'h3333_3333, 0);
    run_txn("tie3", 1, 1, 32'h8000_001C, 0, 32'h8000_040C, 32'd0, 4'd0, 3'b010, 1, 0, 32'h4444_4444, 0);

    // Minimum-latency fetch, started in the previous response cycle.
    run_txn("fetch", 1, 0, 32'h8000_0000, 0, 32'd0, 32'd0, 4'd0, 3'd0, 0, 0, 32'h0000_0413, 0);
    // Store held in REQ for five not-ready cycles.
    run_txn("store", 0, 1, 32'd0, 1, 32'h8000_0100, 32'hDEAD_BEEF, 4'b0011, 3'b001, 5, 1, 32'd0, 0);
    // Slave never answers: forced error response.
    run_txn("tmo", 0, 1, 32'd0, 0, 32'h8000_0200, 32'd0, 4'd0, 3'b010, 0, 100, 32'd0, 0);
    // Answer arriving exactly on the timeout cycle still wins.
    run_txn("tmo_edge", 1, 0, 32'h8000_0020, 0, 32'd0, 32'd0, 4'd0, 3'd0, 1, TO, 32'hABCD_0001, 0);
    // Slave error propagates with its data.
    run_txn("slverr", 1, 0, 32'h8000_0024, 0, 32'd0, 32'd0, 4'd0, 3'd0, 0, 2, 32'h1234_5678, 1);

    // Randomized transactions with random idle gaps.
    for (int t = 0; t < 40; t++) begin
      int sel, gap;
      sel = $urandom_range(1, 3);
      gap = $urandom_range(0, 2);
      run_txn("rnd", sel[0], sel[1], $urandom, 1'($urandom_range(0, 1)), $urandom, $urandom,
              4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), $urandom_range(0, 3),
              $urandom_range(0, TO + 2), $urandom, 1'($urandom_range(0, 1)));
      for (int g = 0; g < gap; g++) tick();
    end

    // Reset in RESP: everything drops at once and a late slave answer is ignored.
    tick();
    b.i_lsu_req = 1'b1; b.i_lsu_wen = 1'b0; b.i_lsu_addr = 32'h8000_0300;
    b.i_lsu_wdata = 32'd0; b.i_lsu_wmask = 4'd0; b.i_lsu_size = 3'b010;
    b.i_ifu_req = 1'b0; b.i_mem_ready = 1'b0; b.i_mem_rvalid = 1'b0;
    tick();
    b.i_lsu_req = 1'b0; b.i_mem_ready = 1'b1;
    chk("rst_pre_gnt", 32'(b.o_lsu_gnt), 32'd1);
    tick();
    b.i_mem_ready = 1'b0;
    chk("rst_pre_busy", 32'(b.o_busy), 32'd1);
    #2 i_reset = 1'b1;
    #1 chk_all_zero("rst_mid");
    tick();
    i_reset = 1'b0;
    last_owner = 1'b0;
    b.i_mem_rvalid = 1'b1; b.i_mem_rdata = 32'hCAFE_F00D; b.i_mem_err = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk_all_zero("rst_after");
    end
    b.i_mem_rvalid = 1'b0;
    run_txn("post_rst_tie", 1, 1, 32'h8000_0000, 0, 32'h8000_0500, 32'd0, 4'd0, 3'b010, 0, 0, 32'h7777_7777, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ysyx_24110006_mem_arbiter.md
# ysyx_24110006_mem_arbiter

Two-master memory arbiter for the multi-cycle core: shares the single memory port between instruction fetch (IFU) and load/store (LSU). It owns one outstanding transaction at a time and routes the response back to the master that issued it. A response timeout converts a hung slave into an error response. It sits between IFU/LSU and the memory/bus bridge.

## Interface
- TIMEOUT, 255: max RESP-state cycles before forced error response; 0 disables timeout (16-bit counter).
- i_clock  in  1  clock
- i_reset  in  1  reset, asynchronous, active-high
- i_ifu_req  in  1  IFU read request (level)
- i_ifu_addr  in  32  IFU fetch address
- o_ifu_gnt  out  1  one-cycle pulse: IFU request accepted, payload latched
- o_ifu_rvalid  out  1  one-cycle pulse: IFU response valid
- o_ifu_rdata  out  32  fetch data, valid with o_ifu_rvalid
- o_ifu_err  out  1  error flag, valid with o_ifu_rvalid
- i_lsu_req  in  1  LSU request (level)
- i_lsu_wen  in  1  1 = store, 0 = load
- i_lsu_addr  in  32  access address
- i_lsu_wdata  in  32  store data
- i_lsu_wmask  in  4  byte write mask
- i_lsu_size  in  3  access size/type (funct3 encoding)
- o_lsu_gnt, o_lsu_rvalid, o_lsu_rdata[31:0], o_lsu_err  out  as IFU counterparts
- o_mem_valid  out  1  request to slave
- o_mem_wen, o_mem_addr[31:0], o_mem_wdata[31:0], o_mem_wmask[3:0], o_mem_size[2:0]  out  latched payload
- i_mem_ready  in  1  slave accepts request when high with o_mem_valid
- i_mem_rvalid  in  1  slave response valid
- i_mem_rdata  in  32  response data
- i_mem_err  in  1  slave error, valid with i_mem_rvalid
- o_busy  out  1  state != IDLE
- o_owner  out  1  current/last owner: 0 = IFU, 1 = LSU

## Operation
- States: IDLE, REQ, RESP.
- IDLE: if any req high, choose owner, latch payload (IFU: wen=0, wmask=0, size=3'b010, wdata=0), pulse owner's gnt next cycle, go REQ.
- Arbitration: single req -> that master. Both -> round-robin: grant the master not equal to last_owner. last_owner resets to IFU, so LSU wins the first tie.
- REQ: o_mem_valid=1, payload stable. i_mem_ready=1 -> RESP, clear timeout counter. No timeout in REQ.
- RESP: o_mem_valid=0. i_mem_rvalid=1 -> register rdata/err to owner, pulse owner's rvalid next cycle, go IDLE. Else counter++; if TIMEOUT!=0 and counter reaches TIMEOUT -> error response (rdata=0, err=1), go IDLE.
- i_mem_rvalid outside RESP ignored. Requests outside IDLE ignored (not queued).
- Master rule: after gnt, req must be low in the cycle its rvalid pulses unless it issues a new request; req high in IDLE is always a new transaction.
- Non-owner rvalid/rdata/err outputs stay 0; rdata is 0 whenever rvalid is 0.

## Timing
- Reset (async): state IDLE, all outputs 0, o_owner=0, last_owner=IFU, counter 0, latched payload 0.
- Req high cycle 0 (IDLE) -> gnt and o_mem_valid cycle 1.
- ready in cycle 1 -> RESP cycle 2; rvalid in cycle 2 -> master rvalid cycle 3; state IDLE cycle 3. Minimum request-to-response: 3 cycles.
- New request seen in cycle 3 -> o_mem_valid cycle 4 (one IDLE cycle between transactions).
- Timeout: rvalid never arrives -> error pulse TIMEOUT+1 cycles after entering RESP.
- Reset mid-transaction: immediate return to reset state; no response pulse issued for the aborted transaction.

## Test plan
- IFU fetch addr 0x8000_0000, ready same cycle, rvalid next with rdata 0x0000_0413 -> o_ifu_gnt cycle 1, o_ifu_rvalid cycle 3 with 0x0000_0413, LSU outputs 0.
- Both req high from reset -> LSU granted first; both kept requesting -> IFU, LSU, IFU alternate grants.
- LSU store addr 0x8000_0100, wdata 0xDEAD_BEEF, wmask 4'b0011, size 3'b001 -> o_mem_* carry exactly these until ready; ready held low 5 cycles -> o_mem_valid held 5+1 cycles, no timeout.
- TIMEOUT=4, slave never asserts rvalid -> o_lsu_rvalid=1, o_lsu_err=1, rdata=0 five cycles after RESP entry; state IDLE.
- Slave returns i_mem_err=1 with rdata 0x1234_5678 -> owner sees err=1, rdata 0x1234_5678.
- Assert i_reset in RESP -> o_busy=0, all outputs 0 immediately; later i_mem_rvalid ignored.
